// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared USART constants and arbiter state encoding
package usart_pkg;

  localparam int BYTE_W         = 8;
  localparam int CLKS_PER_BIT_W = 12;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SEND      = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin winner search after last_grant
module rr_priority_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_grant,
  output logic [PORT_W-1:0]    winner,
  output logic                 any
);

  logic [PORT_W-1:0] idx;

  // Walk ports starting one past last_grant, wrapping, first requester wins
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      idx = PORT_W'((int'(last_grant) + off) % NUM_PORTS);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// rtl/usart_tx_arbiter.sv - round-robin arbiter sharing one usart_tx; watchdog via USART_TX_ARB_TIMEOUT_EN
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int          NUM_PORTS      = 4,
  parameter int          PORT_W         = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                        serial_clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [BYTE_W*NUM_PORTS-1:0] req_data,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic                        tx_done,
  output logic                        busy,
  output logic                        done_valid,
  output logic [PORT_W-1:0]           done_id
`ifdef USART_TX_ARB_TIMEOUT_EN
  ,
  output logic                        timeout
`endif
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || PORT_W != $clog2(NUM_PORTS) || TIMEOUT_CYCLES == 16'd0)
  begin : g_bad_cfg
    $error("usart_tx_arbiter: unsupported parameter combination");
  end

  arb_state_t               state_q, state_d;
  logic [PORT_W-1:0]        last_grant_q, last_grant_d;
  logic [PORT_W-1:0]        cur_id_q, cur_id_d;
  logic [BYTE_W-1:0]        tx_data_d;
  logic                     tx_valid_d;
  logic [NUM_PORTS-1:0]     req_ready_d;
  logic                     done_valid_d;
  logic [PORT_W-1:0]        done_id_d;
  logic [PORT_W-1:0]        pick_id;
  logic                     pick_any;
  logic [BYTE_W-1:0]        pick_data;

`ifdef USART_TX_ARB_TIMEOUT_EN
  logic [15:0]              tmo_cnt_q, tmo_cnt_d;
  logic                     timeout_d;
`endif

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .winner     (pick_id),
    .any        (pick_any)
  );

  assign busy = (state_q != ARB_IDLE);

  // Byte mux for the winning port, written as a compare loop to keep index widths exact
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_id == PORT_W'(i)) pick_data = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Next-state and registered-output logic for the grant/load/accept/done sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    tx_data_d    = tx_data;
    tx_valid_d   = tx_valid;
    req_ready_d  = '0;
    done_valid_d = 1'b0;
    done_id_d    = done_id;
`ifdef USART_TX_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          tx_data_d  = pick_data;
          cur_id_d   = pick_id;
          tx_valid_d = 1'b1;
          for (int i = 0; i < NUM_PORTS; i++) begin
            req_ready_d[i] = (pick_id == PORT_W'(i));
          end
          state_d    = ARB_SEND;
`ifdef USART_TX_ARB_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end

      ARB_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (tx_done) begin
            done_valid_d = 1'b1;
            done_id_d    = cur_id_q;
            last_grant_d = cur_id_q;
            state_d      = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT_DONE;
          end
        end
      end

      ARB_WAIT_DONE: begin
        if (tx_done) begin
          done_valid_d = 1'b1;
          done_id_d    = cur_id_q;
          last_grant_d = cur_id_q;
          state_d      = ARB_IDLE;
        end
      end

      default: begin
        state_d    = ARB_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

`ifdef USART_TX_ARB_TIMEOUT_EN
    // Watchdog overrides a normal completion if both land on the same edge
    if (state_q == ARB_SEND || state_q == ARB_WAIT_DONE) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
      if (tmo_cnt_q == TIMEOUT_CYCLES - 16'd1) begin
        timeout_d    = 1'b1;
        tx_valid_d   = 1'b0;
        done_valid_d = 1'b0;
        done_id_d    = done_id;
        last_grant_d = cur_id_q;
        state_d      = ARB_IDLE;
      end
    end
`endif
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge serial_clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      cur_id_q     <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      req_ready    <= '0;
      done_valid   <= 1'b0;
      done_id      <= '0;
`ifdef USART_TX_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      tx_data      <= tx_data_d;
      tx_valid     <= tx_valid_d;
      req_ready    <= req_ready_d;
      done_valid   <= done_valid_d;
      done_id      <= done_id_d;
`ifdef USART_TX_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      timeout      <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb/tb_usart_tx_arbiter.sv - vector-table bench for usart_tx_arbiter; watchdog case under USART_TX_ARB_TIMEOUT_EN
module tb_usart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;
  logic        busy;
  logic        done_valid;
  logic [1:0]  done_id;
`ifdef USART_TX_ARB_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usart_tx_arbiter #(
    .NUM_PORTS      (4),
    .PORT_W         (2),
    .TIMEOUT_CYCLES (16'd20)
  ) dut (
    .serial_clock (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .busy         (busy),
    .done_valid   (done_valid),
    .done_id      (done_id)
`ifdef USART_TX_ARB_TIMEOUT_EN
    ,
    .timeout      (timeout)
`endif
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        tr;
    logic        td;
    logic        etv;
    logic [3:0]  err;
    logic [7:0]  edata;
    logic        ebusy;
    logic        edv;
    logic [1:0]  eid;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D_ALL = 32'h13121110;
  localparam logic [31:0] D_P2  = 32'h00AA0000;

  task automatic add(input logic rst, input logic [3:0] rv, input logic [31:0] rd,
                     input logic tr, input logic td, input logic etv, input logic [3:0] err,
                     input logic [7:0] edata, input logic ebusy, input logic edv,
                     input logic [1:0] eid);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rd = rd; v.tr = tr; v.td = td;
    v.etv = etv; v.err = err; v.edata = edata; v.ebusy = ebusy; v.edv = edv; v.eid = eid;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] rv, input logic [31:0] rd,
                       input logic tr, input logic td);
    reset = rst; req_valid = rv; req_data = rd; tx_ready = tr; tx_done = td;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'b0, 32'h0, 1'b0, 1'b0);

    // single request on port 2
    add(1, 4'b0000, D_P2, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0000, D_P2, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0100, D_P2, 0, 0, 1, 4'b0100, 8'hAA, 1, 0, 0);
    add(0, 4'b0000, D_P2, 0, 0, 1, 4'b0000, 8'hAA, 1, 0, 0);
    add(0, 4'b0000, D_P2, 1, 0, 0, 4'b0000, 8'h00, 1, 0, 0);
    add(0, 4'b0000, D_P2, 0, 0, 0, 4'b0000, 8'h00, 1, 0, 0);
    add(0, 4'b0000, D_P2, 0, 1, 0, 4'b0000, 8'h00, 0, 1, 2);
    add(0, 4'b0000, D_P2, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0);
    // spurious tx_done while idle
    add(0, 4'b0000, D_P2, 0, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
    // reset so port 0 leads the round robin
    add(1, 4'b0000, D_ALL, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add(0, 4'b1111, D_ALL, 0, 0, 1, 4'(1 << (k % 4)), 8'(8'h10 + (k % 4)), 1, 0, 0);
      add(0, 4'b1111, D_ALL, 1, 0, 0, 4'b0000, 8'h00, 1, 0, 0);
      add(0, 4'b1111, D_ALL, 0, 1, 0, 4'b0000, 8'h00, 0, 1, 2'(k % 4));
    end
    // tx_ready and tx_done together in SEND: straight back to idle
    add(0, 4'b1111, D_ALL, 0, 0, 1, 4'b0010, 8'h11, 1, 0, 0);
    add(0, 4'b0000, D_ALL, 1, 1, 0, 4'b0000, 8'h00, 0, 1, 1);
    add(0, 4'b0000, D_ALL, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0000, D_ALL, 0, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
    // reset while waiting for done
    add(0, 4'b1111, D_ALL, 0, 0, 1, 4'b0100, 8'h12, 1, 0, 0);
    add(0, 4'b0000, D_ALL, 1, 0, 0, 4'b0000, 8'h00, 1, 0, 0);
    add(1, 4'b0000, D_ALL, 0, 0, 0, 4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b0000, D_ALL, 0, 1, 0, 4'b0000, 8'h00, 0, 0, 0);
    add(0, 4'b1111, D_ALL, 0, 0, 1, 4'b0001, 8'h10, 1, 0, 0);
    add(0, 4'b0000, D_ALL, 1, 1, 0, 4'b0000, 8'h00, 0, 1, 0);
    // port 1 withdraws before it is granted, port 3 wins
    add(0, 4'b0001, D_ALL, 0, 0, 1, 4'b0001, 8'h10, 1, 0, 0);
    add(0, 4'b1010, D_ALL, 1, 0, 0, 4'b0000, 8'h00, 1, 0, 0);
    add(0, 4'b1000, D_ALL, 0, 1, 0, 4'b0000, 8'h00, 0, 1, 0);
    add(0, 4'b1000, D_ALL, 0, 0, 1, 4'b1000, 8'h13, 1, 0, 0);
    add(0, 4'b0000, D_ALL, 1, 1, 0, 4'b0000, 8'h00, 0, 1, 3);

    foreach (vecs[r]) begin
      drive(vecs[r].rst, vecs[r].rv, vecs[r].rd, vecs[r].tr, vecs[r].td);
      tick();
      chk("tx_valid", r, 32'(tx_valid), 32'(vecs[r].etv));
      chk("req_ready", r, 32'(req_ready), 32'(vecs[r].err));
      chk("busy", r, 32'(busy), 32'(vecs[r].ebusy));
      chk("done_valid", r, 32'(done_valid), 32'(vecs[r].edv));
      if (vecs[r].etv) chk("tx_data", r, 32'(tx_data), 32'(vecs[r].edata));
      if (vecs[r].edv) chk("done_id", r, 32'(done_id), 32'(vecs[r].eid));
      if (vecs[r].rst) begin
        chk("rst_tx_data", r, 32'(tx_data), 32'h0);
        chk("rst_done_id", r, 32'(done_id), 32'h0);
      end
    end

    // tx_done in SEND without tx_ready is ignored; tx_valid/tx_data hold through a long stall
    drive(0, 4'b0010, D_ALL, 0, 0);
    tick();
    chk("hold_grant", 100, 32'(req_ready), 32'h2);
    drive(0, 4'b0000, 32'hDEADBEEF, 0, 1);
    tick();
    chk("early_done_dv", 101, 32'(done_valid), 32'h0);
    chk("early_done_tv", 101, 32'(tx_valid), 32'h1);
    drive(0, 4'b0000, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold_tv", 102 + i, 32'(tx_valid), 32'h1);
      chk("hold_data", 102 + i, 32'(tx_data), 32'h11);
    end
    drive(0, 4'b0000, D_ALL, 1, 0);
    tick();
    chk("accept_tv", 110, 32'(tx_valid), 32'h0);
    drive(0, 4'b0000, D_ALL, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_busy", 111 + i, 32'(busy), 32'h1);
      chk("wait_dv", 111 + i, 32'(done_valid), 32'h0);
    end
    drive(0, 4'b0000, D_ALL, 0, 1);
    tick();
    chk("late_dv", 116, 32'(done_valid), 32'h1);
    chk("late_id", 116, 32'(done_id), 32'h1);
    drive(0, 4'b0000, D_ALL, 0, 0);
    tick();

`ifdef USART_TX_ARB_TIMEOUT_EN
    // tx_ready never comes: watchdog fires 20 cycles after entering SEND
    drive(0, 4'b0001, D_ALL, 0, 0);
    tick();
    chk("tmo_grant", 200, 32'(req_ready), 32'h1);
    drive(0, 4'b0000, D_ALL, 0, 0);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("tmo_early", 200 + i, 32'(timeout), 32'h0);
      chk("tmo_tv", 200 + i, 32'(tx_valid), 32'h1);
    end
    tick();
    chk("tmo_pulse", 220, 32'(timeout), 32'h1);
    chk("tmo_tv_clr", 220, 32'(tx_valid), 32'h0);
    chk("tmo_busy", 220, 32'(busy), 32'h0);
    chk("tmo_no_done", 220, 32'(done_valid), 32'h0);
    tick();
    chk("tmo_one_cycle", 221, 32'(timeout), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usart_tx_arbiter.md
# usart_tx_arbiter

Shares one `usart_tx` serialiser between `NUM_PORTS` byte requesters using round-robin arbitration. Sits between the requesters and the `usart_tx` instance, and runs on the same `serial_clock`. It sequences each transfer as grant, then load, then wait for accept, then wait for done. It also reports which port's byte completed.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of requesters (2..8).
- `PORT_W`, default 2: width of port index; must equal clog2(`NUM_PORTS`).
- `TIMEOUT_CYCLES`, default 16'hFFFF: watchdog limit. Used only when `USART_TX_ARB_TIMEOUT_EN` is defined.

Ports:
- `serial_clock`, in, 1: sole clock; everything is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `NUM_PORTS`: per-port byte pending.
- `req_data`, in, 8*`NUM_PORTS`: port i byte at [8i+7:8i].
- `req_ready`, out, `NUM_PORTS`: one-cycle accept pulse to the winning port.
- `tx_data`, out, 8: to `usart_tx` `data_in`.
- `tx_valid`, out, 1: to `usart_tx` `valid`.
- `tx_ready`, in, 1: from `usart_tx` `ready`; high means the byte has been accepted and shifting has started.
- `tx_done`, in, 1: from `usart_tx` `done`; pulses at the end of the stop bit.
- `busy`, out, 1: high whenever the arbiter is not in IDLE.
- `done_valid`, out, 1: one-cycle pulse when a byte completes.
- `done_id`, out, `PORT_W`: port index of the completed byte; valid while `done_valid` is high.
- `timeout`, out, 1: one-cycle watchdog pulse. Only exists when the macro is defined.

## Operation
- The state machine has three states: IDLE, SEND and WAIT_DONE.
- Reset values:
  - State is IDLE.
  - `tx_valid`, `req_ready`, `busy`, `done_valid` and `timeout` are 0.
  - `tx_data` and `done_id` are 0.
  - `last_grant` is `NUM_PORTS`-1, so port 0 has first priority after reset.
- **IDLE:** if any `req_valid` is high, select the winner.
  - Search starts at `last_grant`+1 and wraps modulo `NUM_PORTS`; the first set bit wins.
  - On that edge: register `tx_data` from the winner's `req_data`, set `cur_id` to the winner, set `tx_valid` and `busy` to 1, pulse the winner's `req_ready`, and go to SEND.
  - If no `req_valid` is high, stay in IDLE.
- **SEND:** hold `tx_valid` and `tx_data` stable.
  - When `tx_ready` is sampled 1: clear `tx_valid` and go to WAIT_DONE.
  - If `tx_done` is also 1 on that same edge, complete immediately: do the done actions and go to IDLE.
- **WAIT_DONE:** on `tx_done`:
  - Pulse `done_valid` with `done_id` = `cur_id`.
  - Set `last_grant` to `cur_id`, clear `busy` and go to IDLE.
- `tx_done` is ignored in IDLE. `tx_done` seen in SEND without `tx_ready` is also ignored.
- Requester rule: hold `req_valid` and `req_data` stable until `req_ready` pulses.
  - `req_data` may change on the cycle after the pulse.
  - A requester that drops `req_valid` before being granted simply loses its turn; this is not an error.
- `req_valid` changes during SEND or WAIT_DONE have no effect. Arbitration samples only in IDLE.
- Reset mid-transfer: all outputs return to their reset values on the next edge. No `done_valid` is issued for the aborted byte.

## Timing
- Grant latency: `req_valid` high in IDLE at edge N gives `tx_valid`=1 and `req_ready` pulse visible after edge N.
- `tx_valid` falls on the edge after the one where `tx_ready`=1 is sampled.
- `done_valid` is high for exactly the cycle after the edge where `tx_done` is sampled.
- Back-to-back transfers: after done, the next `tx_valid` rises one cycle later. IDLE costs a single cycle.
- Fairness: with all ports continuously requesting, grants run in order 0,1,…,`NUM_PORTS`-1,0,… with no port skipped.

## Configuration
- `USART_TX_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to SEND and increments each cycle in SEND or WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout` for 1 cycle, clear `tx_valid`, set `last_grant` to `cur_id`, go to IDLE, and do not pulse `done_valid`.
- `USART_TX_ARB_TIMEOUT_EN` undefined: no counter and no `timeout` port. The arbiter waits on `tx_ready` and `tx_done` indefinitely.

## Structure
- Shared package `usart_pkg` holds:
  - the state encoding constants `ARB_IDLE`, `ARB_SEND` and `ARB_WAIT_DONE`;
  - the byte width constant (8);
  - the clocks-per-bit width (12), shared with `usart_tx`.
- One sub-module: `rr_priority_pick`. It is combinational; it takes the request vector and `last_grant`, and returns a winner index and an `any` flag.

## Test plan
- Single request: port 2 holds `req_valid` with 8'hAA. Expect `req_ready`[2] pulse, `tx_data`=8'hAA, and `tx_valid` until `tx_ready`. After a `tx_done` pulse, expect `done_valid` with `done_id`=2 and `busy`=0.
- Round robin: all four ports request continuously with 8'h10..8'h13. Expect `done_id` sequence 0,1,2,3,0 and `tx_data` matching each port.
- Simultaneous `tx_ready` and `tx_done` in SEND: expect `done_valid` the next cycle and a return to IDLE without visiting WAIT_DONE.
- Reset asserted in WAIT_DONE: expect `tx_valid`=0, `busy`=0, no `done_valid`, and port 0 granted first afterwards.
- Late/spurious `tx_done`:
  - Pulse in IDLE: expect no `done_valid`.
  - Port 1 drops `req_valid` before grant while port 3 is requesting: expect port 3 granted.
- With `USART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, never assert `tx_ready`: expect a `timeout` pulse 20 cycles after entering SEND, `tx_valid`=0, and a return to IDLE.
